// File: rtl/dragonfang_pkg.sv
// Shared decode types for the Dragonfang vector execution stage.
// Only the fields consumed by the division unit are carried here.
package dragonfang_pkg;

   typedef struct packed {
      logic [1:0] division_op;   // 00 vdivu, 01 vdiv, 10 vremu, 11 vrem
      logic [1:0] vsew;          // 00 e8, 01 e16, 10 e32, 11 e64
   } execution_vector_t;

endpackage

// File: rtl/vector_division_unit.sv
// Lane-parallel RISC-V V divide/remainder unit (e8/e16/e32/e64 lanes), result registered one cycle later.
// Remainder ops exist only with VECTOR_DIVISION_UNIT_REM_EN defined; otherwise vrem/vremu return zero.
module vector_division_unit
   import dragonfang_pkg::*;
#(
   parameter int ELEN = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  execution_vector_t execution_vector,
   input  logic              valid_i,
   input  logic [ELEN-1:0]   vs2,
   input  logic [ELEN-1:0]   vs1,
   output logic [ELEN-1:0]   vd,
   output logic              valid_o
);

   logic            signed_op;
   logic            rem_op;
   logic [ELEN-1:0] res_w [4];
   logic [ELEN-1:0] vd_d, vd_q;
   logic            valid_d, valid_q;

   assign signed_op = execution_vector.division_op[0];
   assign rem_op    = execution_vector.division_op[1];

   // One divider array per element width; the output mux picks the active one.
   for (genvar s = 0; s < 4; s++) begin : g_sew
      localparam int W = 8 << s;
      localparam int N = ELEN / W;

      logic [ELEN-1:0] lane_res;

      for (genvar k = 0; k < N; k++) begin : g_lane
         logic [W-1:0] dvd, dvs, dvd_mag, dvs_mag, dvs_div, q_mag, q, res;
         logic         dvd_neg, dvs_neg, div_zero, ovf;

         assign dvd      = vs2[k*W +: W];
         assign dvs      = vs1[k*W +: W];
         assign dvd_neg  = signed_op & dvd[W-1];
         assign dvs_neg  = signed_op & dvs[W-1];
         assign dvd_mag  = dvd_neg ? -dvd : dvd;
         assign dvs_mag  = dvs_neg ? -dvs : dvs;
         assign div_zero = (dvs == '0);
         assign ovf      = signed_op && (dvd == {1'b1, {(W-1){1'b0}}}) && (dvs == '1);
         // Keep the divider free of a zero divisor; the result is overridden anyway.
         assign dvs_div  = div_zero ? {{(W-1){1'b0}}, 1'b1} : dvs_mag;
         assign q_mag    = dvd_mag / dvs_div;

         always_comb begin
            q = (dvd_neg ^ dvs_neg) ? -q_mag : q_mag;
            if (div_zero) begin
               q = '1;
            end else if (ovf) begin
               q = dvd;
            end
         end

`ifdef VECTOR_DIVISION_UNIT_REM_EN
         logic [W-1:0] r_mag, r;

         assign r_mag = dvd_mag % dvs_div;

         always_comb begin
            r = dvd_neg ? -r_mag : r_mag;
            if (div_zero) begin
               r = dvd;
            end else if (ovf) begin
               r = '0;
            end
         end

         assign res = rem_op ? r : q;
`else
         assign res = rem_op ? '0 : q;
`endif

         assign lane_res[k*W +: W] = res;
      end

      assign res_w[s] = lane_res;
   end

   always_comb begin
      vd_d    = vd_q;
      valid_d = 1'b0;
      if (valid_i) begin
         vd_d    = res_w[execution_vector.vsew];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vd_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         vd_q    <= vd_d;
         valid_q <= valid_d;
      end
   end

   assign vd      = vd_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_vector_division_unit.sv
// Directed and randomized checks of vector_division_unit against a lane-level arithmetic model.
module tb_vector_division_unit;
   import dragonfang_pkg::*;

`ifdef VECTOR_DIVISION_UNIT_REM_EN
   localparam bit REM_EN = 1'b1;
`else
   localparam bit REM_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              valid_i = 1'b0;
   execution_vector_t ev = '0;
   logic [63:0]       vs2 = '0;
   logic [63:0]       vs1 = '0;
   logic [63:0]       vd;
   logic              valid_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vector_division_unit #(.ELEN(64)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .execution_vector (ev),
      .valid_i          (valid_i),
      .vs2              (vs2),
      .vs1              (vs1),
      .vd               (vd),
      .valid_o          (valid_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] sew,
                        input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      valid_i        = v;
      ev.division_op = op;
      ev.vsew        = sew;
      vs2            = a;
      vs1            = b;
   endtask

   task automatic step(input logic v, input logic [1:0] op, input logic [1:0] sew,
                       input logic [63:0] a, input logic [63:0] b);
      drive(v, op, sew, a, b);
      @(posedge clk);
      #1;
   endtask

   // One lane computed with native signed/unsigned 64-bit arithmetic plus the RVV special cases.
   function automatic logic [63:0] ref_lane(input logic [1:0] op, input int w,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0] mask, a, b, q, r;
      longint      sa, sb, minv;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      a    = a_in & mask;
      b    = b_in & mask;
      if (b == 64'd0) begin
         q = mask;
         r = a;
      end else if (op[0]) begin
         sa   = $signed(a << (64 - w)) >>> (64 - w);
         sb   = $signed(b << (64 - w)) >>> (64 - w);
         minv = -(longint'(1) << (w - 1));
         if (sa == minv && sb == -1) begin
            q = a;
            r = 64'd0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return (op[1] ? (REM_EN ? r : 64'd0) : q) & mask;
   endfunction

   function automatic logic [63:0] ref_vec(input logic [1:0] op, input logic [1:0] sew,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [63:0] res;
      int          w;
      w   = 8 << sew;
      res = '0;
      for (int k = 0; k < 64 / w; k++)
         res |= ref_lane(op, w, a >> (k * w), b >> (k * w)) << (k * w);
      return res;
   endfunction

   initial begin
      logic [1:0]  op, sew;
      logic [63:0] a, b, lm, exp, last;
      int          w;

      // Reset held with live traffic on the inputs.
      valid_i = 1'b1;
      ev      = '0;
      vs2     = {$urandom(), $urandom()};
      vs1     = {$urandom(), $urandom()};
      repeat (2) @(posedge clk);
      #1;
      check("reset_vd", vd, 64'h0);
      check("reset_valid", {63'd0, valid_o}, 64'd0);

      drive(1'b1, 2'b00, 2'b11, 64'd100, 64'd7);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_vdivu", vd, 64'd14);
      check("first_valid", {63'd0, valid_o}, 64'd1);

      step(1'b1, 2'b01, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      check("vdiv_trunc", vd, 64'hFFFF_FFFF_FFFF_FFFD);
      step(1'b1, 2'b11, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      check("vrem_sign", vd, REM_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);

      step(1'b1, 2'b00, 2'b01, 64'hFFFF_0064_0007_8000, 64'h0002_000A_0007_0100);
      check("lane_iso16", vd, 64'h7FFF_000A_0001_0080);

      step(1'b1, 2'b00, 2'b10, 64'h1234_5678_8000_0001, 64'h0000_0000_0000_0003);
      check("divzero_vdivu", vd, 64'hFFFF_FFFF_2AAA_AAAB);
      // 0x80000001 is exactly 3 * 0x2AAAAAAB, so lane 0 leaves no remainder.
      step(1'b1, 2'b10, 2'b10, 64'h1234_5678_8000_0001, 64'h0000_0000_0000_0003);
      check("divzero_vremu", vd, REM_EN ? 64'h1234_5678_0000_0000 : 64'h0);

      step(1'b1, 2'b01, 2'b00, 64'h8080_8080_8080_8080, 64'hFFFF_FFFF_FFFF_FFFF);
      check("ovf_vdiv", vd, 64'h8080_8080_8080_8080);
      step(1'b1, 2'b11, 2'b00, 64'h8080_8080_8080_8080, 64'hFFFF_FFFF_FFFF_FFFF);
      check("ovf_vrem", vd, 64'h0);
      step(1'b1, 2'b00, 2'b00, 64'h8080_8080_8080_8080, 64'hFFFF_FFFF_FFFF_FFFF);
      check("ovf_vdivu", vd, 64'h0);

      step(1'b1, 2'b01, 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      check("ovf_vdiv64", vd, 64'h8000_0000_0000_0000);
      step(1'b1, 2'b01, 2'b10, 64'h0000_0005_FFFF_FFF6, 64'h0000_0000_0000_0003);
      check("divzero_signed32", vd, 64'hFFFF_FFFF_FFFF_FFFD);
      last = vd;

      // Idle cycle: output holds, valid drops.
      step(1'b0, 2'b00, 2'b00, {$urandom(), $urandom()}, {$urandom(), $urandom()});
      check("idle_hold_vd", vd, last);
      check("idle_valid", {63'd0, valid_o}, 64'd0);

      // Back-to-back random sweep across every op and element width.
      for (int i = 0; i < 1000; i++) begin
         op  = 2'($urandom_range(0, 3));
         sew = 2'($urandom_range(0, 3));
         w   = 8 << sew;
         a   = {$urandom(), $urandom()};
         b   = {$urandom(), $urandom()};
         for (int k = 0; k < 64 / w; k++) begin
            lm = ((w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1)) << (k * w);
            case ($urandom_range(0, 7))
               0: b &= ~lm;
               1: begin
                  a = (a & ~lm) | ((64'd1 << (w - 1)) << (k * w));
                  b |= lm;
               end
               2: b = (b & ~lm) | (64'($urandom_range(1, 7)) << (k * w));
               default: ;
            endcase
         end
         exp = ref_vec(op, sew, a, b);
         step(1'b1, op, sew, a, b);
         check("sweep_vd", vd, exp);
         check("sweep_valid", {63'd0, valid_o}, 64'd1);
      end

      // Reset arriving while an operation is pending.
      drive(1'b1, 2'b00, 2'b11, 64'd1000, 64'd3);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_async_vd", vd, 64'h0);
      @(posedge clk);
      #1;
      check("midreset_vd", vd, 64'h0);
      check("midreset_valid", {63'd0, valid_o}, 64'd0);
      drive(1'b1, 2'b01, 2'b00, 64'h0102_0304_F9F9_7F80, 64'h0101_0202_0202_FF01);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_vd", vd, ref_vec(2'b01, 2'b00, 64'h0102_0304_F9F9_7F80, 64'h0101_0202_0202_FF01));
      check("post_reset_valid", {63'd0, valid_o}, 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
